lms_adapt_ctrl: RTL
===================

Name: lms_adapt_ctrl

Overview:
- Adaptation scheduler for the FIR/LMS equalizer datapath.
- Decides when the LMS engine may update coefficients, selects the step-size shift (training vs tracking), and sequences forced coefficient loads from the SPI debug unit.
- Detects convergence by windowed accumulation of |e| and falls back to training on divergence.
- Sits between the debug unit, the LMS error output and the LMS update/step-size controls.

Parameters:
- NBE, 9: width of signed error input.
- WIN_LOG2, 6: log2 of the convergence window, counted in valid samples.
- THR, 320: convergence threshold on the window |e| sum (unsigned).
- HOLD_WIN, 2: consecutive windows below THR required to declare convergence.
- MU_TRAIN, 2: step-size right-shift used in TRAIN (and in all non-TRACK states).
- MU_TRACK, 5: step-size right-shift used in TRACK.
- DECIM, 1: issue one update per DECIM valid samples (DECIM ≥ 1).
- LOAD_WAIT, 2: cycles spent in LOAD after the load pulse.
- Derived: NBACC = NBE + WIN_LOG2 (accumulator width).

Ports:
- clkA, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- i_start, in, 1: level/pulse request to begin adaptation.
- i_stop, in, 1: freeze adaptation.
- i_force_req, in, 1: request load of debug-forced coefficients.
- i_valid, in, 1: new error sample present on i_err this cycle.
- i_err, in, NBE: signed LMS error sample.
- o_upd_en, out, 1: one-cycle LMS update strobe.
- o_mu_shift, out, 3: step-size right-shift to LMS.
- o_coeff_load, out, 1: one-cycle pulse driven to the LMS debug_load input.
- o_state, out, 3: IDLE=0, LOAD=1, TRAIN=2, TRACK=3, FREEZE=4.
- o_converged, out, 1: high while in TRACK.
- o_err_acc, out, NBACC: |e| sum of the last completed window.

Behaviour:
- **Reset** (sampled on posedge clkA while reset=1): state=IDLE; o_upd_en=0, o_coeff_load=0, o_converged=0, o_err_acc=0, o_mu_shift=MU_TRAIN; all counters and the accumulator cleared. Reset overrides everything, including mid-window and mid-LOAD.
- **Request priority** when several are high in one cycle: i_stop > i_force_req > i_start.
- **IDLE:**
  - i_force_req → LOAD.
  - i_start → TRAIN.
  - i_stop is ignored.
- **LOAD:**
  - o_coeff_load=1 exactly in the first LOAD cycle; the pulse is registered, so it appears on the cycle after the request.
  - Stays in LOAD for LOAD_WAIT further cycles, then returns to the origin state: IDLE→IDLE, FREEZE→FREEZE, TRAIN→TRAIN, TRACK→TRAIN (coefficients changed, reconverge).
  - Requests arriving during LOAD are ignored. o_upd_en=0 throughout.
- **TRAIN:**
  - o_mu_shift=MU_TRAIN.
  - Every i_valid: acc += |i_err|; the sample counter increments; the decimation counter increments mod DECIM.
  - o_upd_en=1 on the cycle after an i_valid whose decimation count was 0. Latency is 1 cycle; the strobe is never wider than 1 cycle.
  - Window end = the i_valid that brings the sample count to 2^WIN_LOG2. That sample is included.
  - At window end: o_err_acc←acc; acc and sample counter cleared.
  - If the window sum < THR, good_cnt++; otherwise good_cnt=0.
  - When good_cnt reaches HOLD_WIN → TRACK.
  - i_stop → FREEZE. i_force_req → LOAD.
- **TRACK:**
  - o_mu_shift=MU_TRACK; o_converged=1.
  - Same accumulation and update strobing as TRAIN.
  - Window sum ≥ 2·THR → TRAIN (divergence); o_converged drops with the state change.
  - i_stop → FREEZE. i_force_req → LOAD.
- **FREEZE:**
  - o_upd_en=0; o_mu_shift=MU_TRAIN; no accumulation.
  - i_force_req → LOAD. i_start → TRAIN.
- **On every state transition:** accumulator, sample counter, decimation counter and good_cnt are cleared. o_err_acc holds its last value.
- **Abs rule:** |e| is an NBE-bit unsigned value; -2^(NBE-1) maps to 2^(NBE-1). The accumulator is NBACC bits and cannot overflow.
- **Ignored input:** i_err is ignored when i_valid=0.
- **o_state** is the registered current state.

Test Plan:
- Bench parameters for all scenarios: WIN_LOG2=2, THR=40, HOLD_WIN=2, DECIM=1, LOAD_WAIT=2.
- i_start, then 8 valids of i_err=+5 → each window sum 20; o_err_acc=20; TRACK entered the cycle after the 8th valid; o_converged=1; o_mu_shift=5; o_upd_en on 8 consecutive post-valid cycles.
- In TRACK, 4 valids of i_err=-30 → o_err_acc=120 ≥ 80 → TRAIN; o_converged=0; o_mu_shift=2.
- i_force_req in TRACK → o_coeff_load high for exactly 1 cycle; o_state=1 for 3 cycles, then 2; no o_upd_en during LOAD despite i_valid=1.
- DECIM=3, i_valid held high in TRAIN → o_upd_en on the cycles following valids 1, 4, 7, 10.
- i_stop and i_force_req together in TRAIN → FREEZE; no o_coeff_load pulse. Then 4 valids of i_err=-256 after restart → o_err_acc=1024, no overflow.
- reset asserted mid-window and mid-LOAD → next cycle o_state=0 and all outputs at their reset values; o_err_acc=0.

Source files
------------

// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: LMS adaptation scheduler with windowed |e| convergence detection and forced-load sequencing
module lms_adapt_ctrl #(
    parameter int NBE = 9,
    parameter int WIN_LOG2 = 6,
    parameter int THR = 320,
    parameter int HOLD_WIN = 2,
    parameter int MU_TRAIN = 2,
    parameter int MU_TRACK = 5,
    parameter int DECIM = 1,
    parameter int LOAD_WAIT = 2,
    localparam int NBACC = NBE + WIN_LOG2
) (
    input  logic                  clkA,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_force_req,
    input  logic                  i_valid,
    input  logic signed [NBE-1:0] i_err,
    output logic                  o_upd_en,
    output logic [2:0]            o_mu_shift,
    output logic                  o_coeff_load,
    output logic [2:0]            o_state,
    output logic                  o_converged,
    output logic [NBACC-1:0]      o_err_acc
);
    localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int GW = $clog2(HOLD_WIN + 1);
    localparam int LW = LOAD_WAIT > 0 ? $clog2(LOAD_WAIT + 1) : 1;
    localparam int AW = NBACC + 1;
    localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);
    localparam logic [GW-1:0] HOLD = GW'(HOLD_WIN);
    localparam logic [LW-1:0] WAIT_LAST = LW'(LOAD_WAIT);
    localparam logic [AW-1:0] THR_LO = AW'(THR);
    localparam logic [AW-1:0] THR_HI = AW'(2 * THR);

    typedef enum logic [2:0] {IDLE, LOAD, TRAIN, TRACK, FREEZE} state_t;

    state_t state_q, state_d, origin_q;
    logic [NBACC-1:0] acc_q, acc_d, err_acc_q, sum;
    logic [WIN_LOG2-1:0] smp_q, smp_d;
    logic [DW-1:0] dec_q, dec_d;
    logic [GW-1:0] good_q, good_d, good_nx;
    logic [LW-1:0] wait_q, wait_d;
    logic [NBE-1:0] mag;
    logic upd_q, upd_d, load_q, load_d, acc_en, win_end;

    // a pending stop/force takes the sample away from the window and the update strobe
    always_comb begin
        mag = i_err[NBE-1] ? -i_err : i_err;
        sum = acc_q + NBACC'(mag);
        acc_en = (state_q == TRAIN || state_q == TRACK) && i_valid && !i_stop && !i_force_req;
        win_end = acc_en && &smp_q;
        good_nx = {1'b0, sum} < THR_LO ? good_q + GW'(1) : '0;
        acc_d = win_end ? '0 : acc_en ? sum : acc_q;
        smp_d = acc_en ? smp_q + WIN_LOG2'(1) : smp_q;
        dec_d = !acc_en ? dec_q : dec_q == DEC_LAST ? '0 : dec_q + DW'(1);
        good_d = win_end ? good_nx : good_q;
        wait_d = state_q == LOAD ? wait_q + LW'(1) : wait_q;
        upd_d = acc_en && dec_q == '0;
        load_d = state_d == LOAD && state_q != LOAD;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_force_req ? LOAD : i_start ? TRAIN : IDLE;
            LOAD:    state_d = wait_q == WAIT_LAST ? origin_q : LOAD;
            TRAIN:   state_d = i_stop ? FREEZE : i_force_req ? LOAD : (win_end && good_nx >= HOLD) ? TRACK : TRAIN;
            TRACK:   state_d = i_stop ? FREEZE : i_force_req ? LOAD : (win_end && {1'b0, sum} >= THR_HI) ? TRAIN : TRACK;
            FREEZE:  state_d = i_stop ? FREEZE : i_force_req ? LOAD : i_start ? TRAIN : FREEZE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkA) begin
        if (reset) begin
            state_q <= IDLE;
            origin_q <= IDLE;
            acc_q <= '0;
            smp_q <= '0;
            dec_q <= '0;
            good_q <= '0;
            wait_q <= '0;
            err_acc_q <= '0;
            upd_q <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_q <= upd_d;
            load_q <= load_d;
            if (win_end) err_acc_q <= sum;
            if (state_d != state_q) begin
                acc_q <= '0;
                smp_q <= '0;
                dec_q <= '0;
                good_q <= '0;
                wait_q <= '0;
                if (state_d == LOAD) origin_q <= state_q == TRACK ? TRAIN : state_q;
            end else begin
                acc_q <= acc_d;
                smp_q <= smp_d;
                dec_q <= dec_d;
                good_q <= good_d;
                wait_q <= wait_d;
            end
        end
    end

    always_comb begin
        o_state = state_q;
        o_converged = state_q == TRACK;
        o_mu_shift = state_q == TRACK ? MU_TRACK[2:0] : MU_TRAIN[2:0];
        o_upd_en = upd_q;
        o_coeff_load = load_q;
        o_err_acc = err_acc_q;
    end
endmodule
